// File: rtl/i2s_tx_stream.sv
// I2S / left-justified stereo serialiser with one-pair holding buffer,
// BCLK/LRCLK generation and underrun repeat of the previous pair.
module i2s_tx_stream #(
  parameter int unsigned CLK_DIV  = 14,
  parameter int unsigned WORD_LEN = 24,
  parameter int unsigned SLOT_LEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                mode_i,
  input  logic [WORD_LEN-1:0] left_i,
  input  logic [WORD_LEN-1:0] right_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                underrun_o,
  output logic                frame_start_o,
  output logic                sdata_o,
  output logic                lrclk_o,
  output logic                bclk_o
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned FRAME = 2 * SLOT_LEN;
  localparam int unsigned POS_W = $clog2(FRAME);

  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(HALF - 1);
  localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0]    SLOT       = POS_W'(SLOT_LEN);
  localparam logic [WORD_LEN-1:0] WORD_MSB   = {1'b1, {(WORD_LEN-1){1'b0}}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                full_q, full_d;
  logic                mode_q, mode_d;
  logic                und_q, und_d;
  logic                fs_q, fs_d;
  logic [WORD_LEN-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WORD_LEN-1:0] shad_l_q, shad_l_d, shad_r_q, shad_r_d;

  logic [POS_W-1:0]    slot_bit;
  logic [POS_W-1:0]    k;
  logic [WORD_LEN-1:0] word;

  always_comb begin
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    full_d   = full_q;
    mode_d   = mode_q;
    und_d    = 1'b0;
    fs_d     = 1'b0;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    shad_l_d = shad_l_q;
    shad_r_d = shad_r_q;
    slot_bit = '0;
    k        = '0;
    word     = '0;

    if (valid_i && !full_q) begin
      full_d   = 1'b1;
      hold_l_d = left_i;
      hold_r_d = right_i;
    end

    if (!enable_i) begin
      cnt_d   = CNT_RELOAD;
      pos_d   = POS_LAST;
      bclk_d  = 1'b0;
      lrclk_d = 1'b1;
      sdata_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d  = CNT_RELOAD;
      bclk_d = !bclk_q;
      if (bclk_q) begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        if (pos_d == '0) begin
          fs_d   = 1'b1;
          mode_d = mode_i;
          if (full_q) begin
            shad_l_d = hold_l_q;
            shad_r_d = hold_r_q;
            full_d   = 1'b0;
          end else begin
            und_d = 1'b1;
          end
        end
        lrclk_d = (pos_d >= SLOT);
        if (lrclk_d) begin
          slot_bit = pos_d - SLOT;
          word     = shad_r_d;
        end else begin
          slot_bit = pos_d;
          word     = shad_l_d;
        end
        // I2S shifts the word one BCLK later; shifts past the word yield 0
        k       = mode_d ? slot_bit : slot_bit - 1'b1;
        sdata_d = (mode_d || slot_bit != '0) ? |(word & (WORD_MSB >> k)) : 1'b0;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= CNT_RELOAD;
      pos_q    <= POS_LAST;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b1;
      sdata_q  <= 1'b0;
      full_q   <= 1'b0;
      mode_q   <= 1'b0;
      und_q    <= 1'b0;
      fs_q     <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      shad_l_q <= '0;
      shad_r_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      full_q   <= full_d;
      mode_q   <= mode_d;
      und_q    <= und_d;
      fs_q     <= fs_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      shad_l_q <= shad_l_d;
      shad_r_q <= shad_r_d;
    end
  end

  assign ready_o       = !full_q;
  assign underrun_o    = und_q;
  assign frame_start_o = fs_q;
  assign sdata_o       = sdata_q;
  assign lrclk_o       = lrclk_q;
  assign bclk_o        = bclk_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: default instance plus a small 16/17/4 instance,
// both compared every cycle against a count-based behavioural model.
module tb_i2s_tx_stream;

  logic        clk;
  logic [1:0]  rst, en, mode, vld;
  logic [31:0] lft [2];
  logic [31:0] rgt [2];
  wire  [1:0]  rdy, und, fs, sd, lr, bc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int CD [2] = '{14, 4};
  int WL [2] = '{24, 16};
  int SL [2] = '{32, 17};

  // model state: n = enabled cycles since reset/disable
  int          n [2];
  bit          full_m [2];
  bit          mode_m [2];
  bit          efs [2];
  bit          eund [2];
  bit          acc [2];
  int          fs_cyc_m [2];
  int          last_fs [2];
  logic [31:0] hl [2];
  logic [31:0] hr [2];
  logic [31:0] shl [2];
  logic [31:0] shr [2];

  i2s_tx_stream dut0 (
    .clk_i(clk), .rst_i(rst[0]), .enable_i(en[0]), .mode_i(mode[0]),
    .left_i(lft[0][23:0]), .right_i(rgt[0][23:0]), .valid_i(vld[0]),
    .ready_o(rdy[0]), .underrun_o(und[0]), .frame_start_o(fs[0]),
    .sdata_o(sd[0]), .lrclk_o(lr[0]), .bclk_o(bc[0])
  );

  i2s_tx_stream #(.CLK_DIV(4), .WORD_LEN(16), .SLOT_LEN(17)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .enable_i(en[1]), .mode_i(mode[1]),
    .left_i(lft[1][15:0]), .right_i(rgt[1][15:0]), .valid_i(vld[1]),
    .ready_o(rdy[1]), .underrun_o(und[1]), .frame_start_o(fs[1]),
    .sdata_o(sd[1]), .lrclk_o(lr[1]), .bclk_o(bc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input int i);
    efs[i]  = 1'b0;
    eund[i] = 1'b0;
    acc[i]  = 1'b0;
    if (rst[i]) begin
      n[i] = 0; full_m[i] = 1'b0; mode_m[i] = 1'b0;
      shl[i] = '0; shr[i] = '0; last_fs[i] = -1;
    end else begin
      acc[i] = vld[i] && !full_m[i];
      if (en[i]) begin
        n[i]++;
        if (n[i] % CD[i] == 0 && ((n[i] / CD[i] - 1) % (2 * SL[i])) == 0) begin
          efs[i] = 1'b1;
          fs_cyc_m[i] = cyc;
          mode_m[i] = mode[i];
          if (full_m[i]) begin
            shl[i] = hl[i]; shr[i] = hr[i]; full_m[i] = 1'b0;
          end else begin
            eund[i] = 1'b1;
          end
        end
      end else begin
        n[i] = 0;
        last_fs[i] = -1;
      end
      if (acc[i]) begin
        hl[i] = lft[i]; hr[i] = rgt[i]; full_m[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input int i);
    int f, pos, k;
    logic e_bc, e_lr, e_sd;
    logic [31:0] w;
    f    = n[i] / CD[i];
    e_bc = ((n[i] / (CD[i] / 2)) % 2) == 1;
    if (f == 0) begin
      e_lr = 1'b1;
      e_sd = 1'b0;
    end else begin
      pos  = (f - 1) % (2 * SL[i]);
      e_lr = pos >= SL[i];
      w    = e_lr ? shr[i] : shl[i];
      k    = (pos % SL[i]) - (mode_m[i] ? 0 : 1);
      e_sd = (k >= 0 && k < WL[i]) ? w[WL[i] - 1 - k] : 1'b0;
    end
    chk($sformatf("bclk%0d", i),     32'(bc[i]),  32'(e_bc));
    chk($sformatf("lrclk%0d", i),    32'(lr[i]),  32'(e_lr));
    chk($sformatf("sdata%0d", i),    32'(sd[i]),  32'(e_sd));
    chk($sformatf("ready%0d", i),    32'(rdy[i]), 32'(!full_m[i]));
    chk($sformatf("fstart%0d", i),   32'(fs[i]),  32'(efs[i]));
    chk($sformatf("underrun%0d", i), 32'(und[i]), 32'(eund[i]));
    if (efs[i]) begin
      if (last_fs[i] >= 0)
        chk($sformatf("period%0d", i), 32'(cyc - last_fs[i]), 32'(2 * SL[i] * CD[i]));
      last_fs[i] = cyc;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) cycle();
  endtask

  task automatic push(input int i, input logic [31:0] l, input logic [31:0] r, output int when);
    when   = -1;
    vld[i] = 1'b1;
    lft[i] = l;
    rgt[i] = r;
    for (int t = 0; t < 3000; t++) begin
      cycle();
      if (acc[i]) begin
        when = cyc;
        break;
      end
    end
    vld[i] = 1'b0;
    if (when < 0) chk($sformatf("push_timeout%0d", i), 32'(0), 32'(1));
  endtask

  function automatic logic [31:0] rnd(input int i);
    logic [31:0] v;
    v = $urandom;
    return (WL[i] == 32) ? v : (v & ((32'd1 << WL[i]) - 1));
  endfunction

  initial begin
    int t;
    rst = 2'b11; en = '0; mode = '0; vld = '0;
    for (int i = 0; i < 2; i++) begin
      lft[i] = '0; rgt[i] = '0; fs_cyc_m[i] = 0;
    end
    cycle();
    rst = 2'b00;
    run(100);

    // defaults, I2S: known pair, then an underrun frame
    push(0, 32'hA5A5A5, 32'h5A5A5A, t);
    en[0] = 1'b1;
    run(2 * 896 + 20);

    // backpressure: second pair waits for the frame-start drain
    push(0, rnd(0), rnd(0), t);
    push(0, rnd(0), rnd(0), t);
    chk("bp_accept_cycle", 32'(t), 32'(fs_cyc_m[0] + 1));
    run(2 * 896);

    // left-justified, switched mid-frame
    mode[0] = 1'b1;
    push(0, rnd(0), rnd(0), t);
    run(2 * 896);
    en[0] = 1'b0;
    run(20);

    // small instance with a mid-frame reset
    push(1, rnd(1), rnd(1), t);
    en[1] = 1'b1;
    run(70);
    vld[1] = 1'b1;
    lft[1] = rnd(1);
    rst[1] = 1'b1;
    cycle();
    rst[1] = 1'b0;
    vld[1] = 1'b0;
    run(50);
    push(1, rnd(1), rnd(1), t);
    run(3 * 136);

    // random traffic, mode flips and occasional disable
    for (int c = 0; c < 1500; c++) begin
      vld[1] = ($urandom % 6) == 0;
      if (vld[1]) begin
        lft[1] = rnd(1);
        rgt[1] = rnd(1);
      end
      if ($urandom % 40 == 0) mode[1] = $urandom % 2;
      en[1] = ($urandom % 400) != 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_stream.md
# i2s_tx_stream

Parametrised I2S/left-justified stereo serialiser, the next generation of the codec transmitter. It accepts independent left/right samples of configurable width over a valid/ready handshake into a one-pair holding buffer. It generates BCLK/LRCLK from the system clock with a configurable divider and shifts samples MSB-first into configurable slots. When the buffer is empty at a frame start, it repeats the previous pair and flags an underrun. It sits between the voice/mixer datapath and the codec DAC pins.

## Interface
- CLK_DIV, 14, system clocks per BCLK period; even, ≥4
- WORD_LEN, 24, sample width in bits; 8..32
- SLOT_LEN, 32, BCLKs per channel slot; ≥WORD_LEN+1
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- enable_i  in  1  run serialiser; low = idle, counters reloaded
- mode_i  in  1  0 = I2S (1-BCLK delay), 1 = left-justified; sampled at frame start
- left_i  in  WORD_LEN  left sample, two's complement
- right_i  in  WORD_LEN  right sample
- valid_i  in  1  sample pair valid
- ready_o  out  1  holding buffer empty; pair accepted when valid_i && ready_o
- underrun_o  out  1  one-cycle pulse: frame started with empty buffer
- frame_start_o  out  1  one-cycle pulse coincident with LRCLK falling (left slot start)
- sdata_o  out  1  serial data to DAC
- lrclk_o  out  1  word select; 0 = left, 1 = right
- bclk_o  out  1  bit clock

## Operation
- State: divider cnt (CLK_DIV/2−1 down to 0), position pos (0..2·SLOT_LEN−1), holding pair + full flag, shadow pair, latched mode.
- Reset (rst_i high at posedge): bclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, underrun_o=0, frame_start_o=0, cnt=CLK_DIV/2−1, pos=2·SLOT_LEN−1, holding empty, shadow=0, mode=I2S. Reset mid-frame aborts immediately; buffered data is discarded.
- enable_i low: cnt, pos, bclk_o, lrclk_o, sdata_o are forced to reset values; the holding buffer and handshake keep working.
- Divider: each enabled cycle cnt−1. At cnt==0, bclk_o toggles and cnt reloads CLK_DIV/2−1.
- All data/LRCLK changes occur in the cycle in which bclk_o goes 1→0. The codec samples on BCLK rising.
- On each BCLK falling, pos advances modulo 2·SLOT_LEN. lrclk_o = (pos ≥ SLOT_LEN). Slot bit s = pos mod SLOT_LEN.
- Frame start (pos wraps to 0):
  - mode is latched.
  - If the buffer is full: shadow ← holding, buffer emptied.
  - Otherwise: shadow is unchanged (previous pair repeated) and underrun_o pulses.
  - frame_start_o pulses.
- Bit output: k = s − (mode ? 0 : 1). sdata_o = channel word[WORD_LEN−1−k] if 0 ≤ k < WORD_LEN, else 0. The channel is left for pos < SLOT_LEN, right otherwise.
- Handshake:
  - ready_o is registered and equals !full.
  - Acceptance sets full on the next cycle.
  - No acceptance can occur in the cycle the buffer is drained (ready_o was 0), so load/accept never collide.
  - A pair accepted in the frame-start cycle while the buffer is empty is not used for that frame; it is used at the next frame start.
- Signed data is serialised as raw bits. There is no sign extension; unused slot bits are 0.

## Timing
- BCLK period = CLK_DIV cycles, 50% duty. The first rising edge occurs after CLK_DIV/2 enabled cycles and the first falling edge after CLK_DIV enabled cycles.
- The first falling edge after enable is the first frame start (pos 2·SLOT_LEN−1 → 0).
- Frame period = 2·SLOT_LEN·CLK_DIV cycles (defaults: 896 cycles, ≈44.6 kHz at 40 MHz).
- sdata_o, lrclk_o, frame_start_o and underrun_o are registered and change in the same cycle as the bclk_o falling edge.
- Latency from handshake acceptance to MSB on sdata_o: up to one frame plus 0 (LJ) or 1 (I2S) BCLK.
- mode_i changes mid-frame take effect at the next frame start only.

## Test plan
- Reset/idle: rst_i=1, then enable_i=0 for 100 cycles. Required: bclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, no pulses.
- I2S defaults: push left=0xA5A5A5, right=0x5A5A5A, then enable.
  - bclk_o rises at cycle 7 and falls at cycle 14; lrclk_o falls at cycle 14 with frame_start_o.
  - sdata_o=0 in slot bit 0, MSB=1 in slot bit 1, bits 25..31 = 0.
  - Right-slot MSB=0 at pos 33.
  - Frame period is 896 cycles.
- Left-justified: mode_i=1, same data. The MSB appears in the same cycle as the LRCLK falling edge; bits 24..31 = 0.
- Underrun: no push before the second frame start. underrun_o pulses for exactly 1 cycle with frame_start_o, and the same pair is retransmitted.
- Backpressure: valid_i held high with two distinct pairs.
  - The first is accepted; ready_o stays 0 until the frame-start cycle.
  - The second is accepted one cycle later and transmitted in the following frame.
- Params WORD_LEN=16, SLOT_LEN=17, CLK_DIV=4, I2S, with a reset pulse mid-frame. Required:
  - Immediate return to reset values.
  - Frame period of 136 cycles after re-enable.
  - 16-bit words with a 1-BCLK delay.
